inst_fetch: RTL

- Program-counter and instruction-fetch stage; sits directly upstream of the operand/PC mux stage.
- Holds the architectural PC and issues word reads to instruction memory over a req/ack handshake.
- Presents the fetched instruction and its PC to decode.
- On advance, loads next_pc as computed by the mux stage from current_pc and the branch immediates.

---
 rtl/inst_fetch.sv | 132 +++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Program-counter and instruction-fetch stage: holds the PC, issues word reads
// over a req/ack handshake, and presents the fetched instruction to decode.
module inst_fetch #(
  parameter int                  DataSize  = 32,
  parameter int                  AddrSize  = 10,
  parameter logic [AddrSize-1:0] ResetPC   = '0,
  parameter int                  CountSize = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AddrSize-1:0]  next_pc,
  input  logic                 advance,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 imem_req,
  output logic [AddrSize-1:0]  imem_addr,
  input  logic                 imem_ack,
  input  logic [DataSize-1:0]  imem_rdata,
  output logic [AddrSize-1:0]  current_pc,
  output logic [DataSize-1:0]  instruction,
  output logic                 inst_valid,
  output logic                 align_err,
  output logic [CountSize-1:0] fetch_count
);

  typedef enum logic {
    ST_REQ   = 1'b0,
    ST_VALID = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [AddrSize-1:0]  pc_q, pc_d;
  logic [AddrSize-1:0]  pending_pc_q, pending_pc_d;
  logic                 flush_pending_q, flush_pending_d;
  logic [DataSize-1:0]  instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 align_err_q, align_err_d;
  logic [CountSize-1:0] count_q, count_d;

  logic                 pc_load;
  logic [AddrSize-1:0]  pc_src;

  function automatic logic [AddrSize-1:0] word_align(input logic [AddrSize-1:0] pc);
    return {pc[AddrSize-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [AddrSize-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pending_pc_d    = pending_pc_q;
    flush_pending_d = flush_pending_q;
    instr_d         = instr_q;
    valid_d         = valid_q;
    align_err_d     = align_err_q;
    count_d         = count_q;
    pc_load         = 1'b0;
    pc_src          = next_pc;

    if (state_q == ST_REQ) begin
      if (imem_ack) begin
        // A flush arriving with the ack wins over any older pending redirect.
        if (flush) begin
          pc_load         = 1'b1;
          pc_src          = next_pc;
          flush_pending_d = 1'b0;
        end else if (flush_pending_q) begin
          pc_load         = 1'b1;
          pc_src          = pending_pc_q;
          flush_pending_d = 1'b0;
        end else begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          count_d = count_q + CountSize'(1);
          state_d = ST_VALID;
        end
      end else if (flush) begin
        // The outstanding read is never abandoned; remember where to go next.
        flush_pending_d = 1'b1;
        pending_pc_d    = next_pc;
      end
    end else begin
      if (flush || (!stall && advance)) begin
        valid_d = 1'b0;
        pc_load = 1'b1;
        pc_src  = next_pc;
        state_d = ST_REQ;
      end
    end

    if (pc_load) begin
      pc_d = word_align(pc_src);
      if (is_misaligned(pc_src)) begin
        align_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_REQ;
      pc_q            <= ResetPC;
      pending_pc_q    <= '0;
      flush_pending_q <= 1'b0;
      instr_q         <= '0;
      valid_q         <= 1'b0;
      align_err_q     <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pending_pc_q    <= pending_pc_d;
      flush_pending_q <= flush_pending_d;
      instr_q         <= instr_d;
      valid_q         <= valid_d;
      align_err_q     <= align_err_d;
      count_q         <= count_d;
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign current_pc  = pc_q;
  assign instruction = instr_q;
  assign inst_valid  = valid_q;
  assign align_err   = align_err_q;
  assign fetch_count = count_q;

endmodule
